// File: rtl/dma_write_burst_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : dma_write_burst_scheduler
// Purpose  : Splits a programmed (base, length) DMA write into AXI4 INCR
//            bursts of at most MAX_BURST beats that never cross a 4KB page.
//            Issues AW requests, hands beat counts to the W data engine,
//            bounds the number of bursts awaiting a B response, collects
//            responses and reports done / error status.
// Ports    : clk, rst_n            - clock, async active-low reset
//            cfg_*                 - start pulse, base address, byte length
//            busy, done, err_*     - status toward the register block
//            m_axi_aw*, m_axi_b*   - AXI4 write address / response channels
//            wcmd_*                - beat-count command to the W engine
// Revision : 1.0 - initial release
// ============================================================================
module dma_write_burst_scheduler #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int LEN_WIDTH       = 20,
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [LEN_WIDTH-1:0]  cfg_len_bytes,
  output logic                  busy,
  output logic                  done,
  output logic                  err_unaligned,
  output logic                  err_slverr,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  input  logic                  m_axi_bvalid,
  input  logic [1:0]            m_axi_bresp,
  output logic                  m_axi_bready,
  output logic                  wcmd_valid,
  output logic [8:0]            wcmd_beats,
  input  logic                  wcmd_ready
);

  localparam int c_bpb      = DATA_WIDTH / 8;
  localparam int c_bpb_log2 = $clog2(c_bpb);
  localparam int c_out_w    = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [c_out_w-1:0]    c_max_out   = c_out_w'(MAX_OUTSTANDING);
  localparam logic [c_out_w-1:0]    c_out_one   = c_out_w'(1);
  localparam logic [ADDR_WIDTH-1:0] c_addr_mask = ADDR_WIDTH'(c_bpb - 1);
  localparam logic [LEN_WIDTH-1:0]  c_len_mask  = LEN_WIDTH'(c_bpb - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_ISSUE = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic [c_out_w-1:0]    r_outstanding;
  logic                  r_burst_active;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err_unaligned;
  logic                  r_err_slverr;
  logic                  r_awvalid;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [7:0]            r_awlen;
  logic                  r_wcmd_valid;
  logic [8:0]            r_wcmd_beats;

  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_b_hs;
  logic        w_b_dec;
  logic        w_burst_complete;
  logic [12:0] w_page_beats;
  logic [8:0]  w_rem_cap;
  logic [8:0]  w_beats;

  assign w_aw_hs = r_awvalid & m_axi_awready;
  assign w_w_hs  = r_wcmd_valid & wcmd_ready;
  // Responses only count while a transfer is active; a stray B when the
  // counter is already empty cannot underflow it.
  assign w_b_hs  = r_busy & m_axi_bvalid;
  assign w_b_dec = w_b_hs & (r_outstanding != '0);

  // A burst is complete once neither channel is still waiting, counting a
  // handshake that happens in this very cycle.
  assign w_burst_complete = r_burst_active
                          & ~(r_awvalid & ~m_axi_awready)
                          & ~(r_wcmd_valid & ~wcmd_ready);

  // 13-bit so that a page-aligned address yields a full page of beats.
  assign w_page_beats = (13'd4096 - {1'b0, r_addr[11:0]}) >> c_bpb_log2;
  assign w_rem_cap    = (r_remaining > LEN_WIDTH'(MAX_BURST)) ?
                        9'(MAX_BURST) : 9'(r_remaining);
  assign w_beats      = ({4'd0, w_rem_cap} > w_page_beats) ?
                        9'(w_page_beats) : w_rem_cap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_addr          <= '0;
      r_len           <= '0;
      r_remaining     <= '0;
      r_outstanding   <= '0;
      r_burst_active  <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_err_unaligned <= 1'b0;
      r_err_slverr    <= 1'b0;
      r_awvalid       <= 1'b0;
      r_awaddr        <= '0;
      r_awlen         <= '0;
      r_wcmd_valid    <= 1'b0;
      r_wcmd_beats    <= '0;
    end else begin
      // Outstanding bookkeeping runs independently of the state machine.
      if (w_aw_hs && !w_b_dec) begin
        r_outstanding <= r_outstanding + c_out_one;
      end else if (!w_aw_hs && w_b_dec) begin
        r_outstanding <= r_outstanding - c_out_one;
      end
      if (w_b_hs && (m_axi_bresp != 2'b00)) begin
        r_err_slverr <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (cfg_start) begin
            r_addr          <= cfg_base_addr;
            r_len           <= cfg_len_bytes;
            r_err_unaligned <= 1'b0;
            r_err_slverr    <= 1'b0;
            r_busy          <= 1'b1;
            r_state         <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (((r_addr & c_addr_mask) != '0) || ((r_len & c_len_mask) != '0)) begin
            r_err_unaligned <= 1'b1;
            r_done          <= 1'b1;
            r_busy          <= 1'b0;
            r_state         <= S_DONE;
          end else if (r_len == '0) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_remaining <= r_len >> c_bpb_log2;
            r_state     <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (w_aw_hs) r_awvalid    <= 1'b0;
          if (w_w_hs)  r_wcmd_valid <= 1'b0;
          if (w_burst_complete) begin
            r_burst_active <= 1'b0;
            r_addr         <= r_addr + (ADDR_WIDTH'(r_wcmd_beats) << c_bpb_log2);
            r_remaining    <= r_remaining - LEN_WIDTH'(r_wcmd_beats);
            if (r_remaining == LEN_WIDTH'(r_wcmd_beats)) begin
              r_state <= S_DRAIN;
            end
          end else if (!r_burst_active && (r_outstanding < c_max_out)) begin
            r_burst_active <= 1'b1;
            r_awvalid      <= 1'b1;
            r_wcmd_valid   <= 1'b1;
            r_awaddr       <= r_addr;
            r_awlen        <= 8'(w_beats - 9'd1);
            r_wcmd_beats   <= w_beats;
          end
        end

        S_DRAIN: begin
          if (r_outstanding == '0) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign err_unaligned = r_err_unaligned;
  assign err_slverr    = r_err_slverr;
  assign m_axi_awaddr  = r_awaddr;
  assign m_axi_awlen   = r_awlen;
  assign m_axi_awsize  = 3'(c_bpb_log2);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_bready  = r_busy;
  assign wcmd_valid    = r_wcmd_valid;
  assign wcmd_beats    = r_wcmd_beats;

endmodule
`default_nettype wire

// File: tb/tb_dma_write_burst_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_write_burst_scheduler
// Purpose  : Self-checking bench for dma_write_burst_scheduler. A reference
//            model derives the expected burst list from base/length with
//            plain arithmetic; randomized ready/response behaviour drives the
//            AXI side and every handshake is compared against that list.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_write_burst_scheduler;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 20;
  localparam int MB = 16;
  localparam int MO = 2;
  localparam int BPB = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_start = 1'b0;
  logic [AW-1:0] cfg_base_addr = '0;
  logic [LW-1:0] cfg_len_bytes = '0;
  logic          busy, done, err_unaligned, err_slverr;
  logic [AW-1:0] m_axi_awaddr;
  logic [7:0]    m_axi_awlen;
  logic [2:0]    m_axi_awsize;
  logic [1:0]    m_axi_awburst;
  logic          m_axi_awvalid, m_axi_awready;
  logic          m_axi_bvalid, m_axi_bready;
  logic [1:0]    m_axi_bresp;
  logic          wcmd_valid, wcmd_ready;
  logic [8:0]    wcmd_beats;

  always #5 clk = ~clk;

  dma_write_burst_scheduler #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW),
    .MAX_BURST(MB), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr), .cfg_len_bytes(cfg_len_bytes),
    .busy(busy), .done(done), .err_unaligned(err_unaligned), .err_slverr(err_slverr),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bresp(m_axi_bresp), .m_axi_bready(m_axi_bready),
    .wcmd_valid(wcmd_valid), .wcmd_beats(wcmd_beats), .wcmd_ready(wcmd_ready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------------------------------------------------------- model
  typedef struct {
    logic [31:0] addr;
    int          beats;
  } burst_t;

  burst_t exp_aw_q[$];
  int     exp_w_q[$];

  function automatic int build_model(input logic [31:0] base, input int len);
    logic [31:0] a;
    int rem, page, b, n;
    exp_aw_q.delete();
    exp_w_q.delete();
    if ((base % BPB) != 0 || (len % BPB) != 0 || len == 0) return 0;
    a = base; rem = len / BPB; n = 0;
    while (rem > 0) begin
      page = (4096 - int'(a % 4096)) / BPB;
      b = rem;
      if (b > MB) b = MB;
      if (b > page) b = page;
      exp_aw_q.push_back('{addr: a, beats: b});
      exp_w_q.push_back(b);
      a = a + 32'(b * BPB);
      rem = rem - b;
      n++;
    end
    return n;
  endfunction

  // ----------------------------------------------------- environment state
  int tb_out  = 0;   // AWs accepted minus Bs accepted
  int aw_cnt  = 0;
  int b_cnt   = 0;
  int err_idx = 99;
  int ready_pct = 70;
  bit b_hold  = 1'b0;
  bit aw_hold = 1'b0;
  bit aw_hs_f = 1'b0, w_hs_f = 1'b0, b_hs_f = 1'b0;
  bit prev_aw_stall = 1'b0, prev_w_stall = 1'b0;
  logic [31:0] prev_awaddr;
  logic [7:0]  prev_awlen;
  logic [8:0]  prev_wbeats;

  // Monitor: values at the falling edge are what the next rising edge sees.
  always @(negedge clk) begin
    aw_hs_f = m_axi_awvalid && m_axi_awready;
    w_hs_f  = wcmd_valid && wcmd_ready;
    b_hs_f  = m_axi_bvalid && m_axi_bready;
    if (!rst_n) begin
      prev_aw_stall = 1'b0;
      prev_w_stall  = 1'b0;
    end else begin
      if (prev_aw_stall) begin
        chk("aw_valid_held", m_axi_awvalid, 1);
        chk("aw_addr_stable", m_axi_awaddr, prev_awaddr);
        chk("aw_len_stable", m_axi_awlen, prev_awlen);
      end
      if (prev_w_stall) begin
        chk("wcmd_valid_held", wcmd_valid, 1);
        chk("wcmd_beats_stable", wcmd_beats, prev_wbeats);
      end
      prev_aw_stall = m_axi_awvalid && !m_axi_awready;
      prev_w_stall  = wcmd_valid && !wcmd_ready;
      prev_awaddr   = m_axi_awaddr;
      prev_awlen    = m_axi_awlen;
      prev_wbeats   = wcmd_beats;

      if (aw_hs_f) begin
        burst_t e;
        aw_cnt++;
        tb_out++;
        chk("outstanding_limit", tb_out <= MO, 1);
        chk("aw_expected", exp_aw_q.size() > 0, 1);
        if (exp_aw_q.size() > 0) begin
          e = exp_aw_q.pop_front();
          chk("awaddr", m_axi_awaddr, e.addr);
          chk("awlen", m_axi_awlen, e.beats - 1);
          chk("awsize", m_axi_awsize, 3'b010);
          chk("awburst", m_axi_awburst, 2'b01);
        end
      end
      if (w_hs_f) begin
        chk("wcmd_expected", exp_w_q.size() > 0, 1);
        if (exp_w_q.size() > 0) chk("wcmd_beats", wcmd_beats, exp_w_q.pop_front());
      end
      if (b_hs_f) begin
        tb_out--;
        b_cnt++;
      end
    end
  end

  // Driver: ready signals and B responder, updated just after each rising edge.
  initial begin
    m_axi_awready = 1'b0;
    wcmd_ready    = 1'b0;
    m_axi_bvalid  = 1'b0;
    m_axi_bresp   = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      m_axi_awready = !aw_hold && ($urandom_range(99) < ready_pct);
      wcmd_ready    = ($urandom_range(99) < ready_pct);
      if (!rst_n) begin
        m_axi_bvalid = 1'b0;
      end else if (m_axi_bvalid && !b_hs_f) begin
        // hold the pending response until accepted
      end else begin
        m_axi_bvalid = 1'b0;
        if (!b_hold && tb_out > 0 && $urandom_range(1) == 1) begin
          m_axi_bvalid = 1'b1;
          m_axi_bresp  = (b_cnt == err_idx) ? 2'b10 : 2'b00;
        end
      end
    end
  end

  // ------------------------------------------------------------ sequences
  int cur_nb;
  bit cur_unal;
  int cur_err;

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_errs"}, {err_unaligned, err_slverr}, 0);
    chk({tag, "_valids"}, {m_axi_awvalid, wcmd_valid, m_axi_bready}, 0);
    chk({tag, "_awaddr"}, m_axi_awaddr, 0);
    chk({tag, "_awlen"}, m_axi_awlen, 0);
    chk({tag, "_wcmd_beats"}, wcmd_beats, 0);
    chk({tag, "_awsize"}, m_axi_awsize, 3'b010);
    chk({tag, "_awburst"}, m_axi_awburst, 2'b01);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    cfg_start = 1'b0;
    @(negedge clk);
    exp_aw_q.delete();
    exp_w_q.delete();
    tb_out = 0;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic start_xfer(input logic [31:0] base, input int len, input int err_i);
    cur_nb   = build_model(base, len);
    cur_unal = ((base % BPB) != 0) || ((len % BPB) != 0);
    cur_err  = err_i;
    err_idx  = err_i;
    b_cnt    = 0;
    aw_cnt   = 0;
    @(posedge clk);
    #1;
    cfg_base_addr = base;
    cfg_len_bytes = LW'(len);
    cfg_start = 1'b1;
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("errs_cleared_on_start", {err_unaligned, err_slverr}, 0);
  endtask

  task automatic finish_xfer();
    int n = 0;
    while (!done && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done, 1);
    if (!done) begin
      do_reset();
    end else begin
      chk("busy_low_at_done", busy, 0);
      chk("err_unaligned", err_unaligned, cur_unal);
      chk("err_slverr", err_slverr, (!cur_unal && cur_err < cur_nb) ? 1 : 0);
      chk("aw_count", aw_cnt, cur_nb);
      chk("aw_all_issued", exp_aw_q.size(), 0);
      chk("wcmd_all_issued", exp_w_q.size(), 0);
      chk("b_all_collected", tb_out, 0);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("err_flags_hold", {err_unaligned, err_slverr},
          {cur_unal, (!cur_unal && cur_err < cur_nb) ? 1'b1 : 1'b0});
    end
  endtask

  task automatic run_xfer(input logic [31:0] base, input int len, input int err_i);
    start_xfer(base, len, err_i);
    finish_xfer();
  endtask

  initial begin
    int n;
    @(negedge clk);
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // aligned single burst, multi-burst, 4KB crossing, zero length
    run_xfer(32'h1000_0000, 64, 99);
    run_xfer(32'h2000_0000, 200, 99);
    run_xfer(32'h1000_0FF0, 64, 99);
    run_xfer(32'h1000_2000, 0, 99);

    // unaligned base, then an aligned start clears the flag
    run_xfer(32'h1000_0007, 64, 99);
    run_xfer(32'h1000_0100, 12, 99);
    run_xfer(32'h1000_0100, 6, 99);

    // outstanding limit with responses withheld
    ready_pct = 100;
    b_hold = 1'b1;
    start_xfer(32'h3000_0000, 256, 99);
    repeat (40) @(negedge clk);
    chk("aw_cnt_at_limit", aw_cnt, MO);
    chk("awvalid_stalled", m_axi_awvalid, 0);
    b_hold = 1'b0;
    finish_xfer();
    ready_pct = 70;

    // awready held low for 5 cycles
    aw_hold = 1'b1;
    start_xfer(32'h4000_0000, 128, 99);
    n = 0;
    while (!m_axi_awvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("awvalid_raised", m_axi_awvalid, 1);
    repeat (5) @(negedge clk);
    chk("awvalid_held_5", m_axi_awvalid, 1);
    chk("awaddr_held_5", m_axi_awaddr, 32'h4000_0000);
    aw_hold = 1'b0;
    finish_xfer();

    // SLVERR on the second of four responses
    run_xfer(32'h5000_0000, 256, 1);

    // reset in the middle of ISSUE, then a normal transfer
    start_xfer(32'h6000_0000, 512, 99);
    n = 0;
    while (aw_cnt < 1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("aw_before_reset", aw_cnt >= 1, 1);
    do_reset();
    run_xfer(32'h6000_1000, 64, 99);

    // randomized transfers
    for (int i = 0; i < 12; i++) begin
      logic [31:0] base;
      int len, nb_guess;
      base = {8'h70, 12'($urandom), 12'($urandom)};
      if ($urandom_range(3) != 0) base[11:0] = 12'hF00 + 12'($urandom_range(63) * 4);
      if ($urandom_range(7) == 0) base[1:0] = 2'($urandom_range(3));
      else base[1:0] = 2'b00;
      len = 4 * $urandom_range(0, 120);
      nb_guess = (len / 4) / MB + 3;
      ready_pct = 30 + $urandom_range(70);
      run_xfer(base, len, $urandom_range(0, nb_guess));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/dma_write_burst_scheduler.md
Name: dma_write_burst_scheduler

Overview:
Sequences the DMA write datapath toward DDR. It takes a programmed (base, length) transfer and splits it into AXI4 INCR write bursts. Each burst is capped at MAX_BURST beats and never crosses a 4KB boundary. The block issues AW requests, hands matching beat-count commands to the W-channel data engine, limits outstanding bursts, collects B responses, and reports done/error to the register block.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, AXI data width; bytes per beat BPB = DATA_WIDTH/8
LEN_WIDTH, 20, width of the byte-length register
MAX_BURST, 16, max beats per burst (1..256)
MAX_OUTSTANDING, 4, max AW-issued bursts awaiting B response

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
cfg_start  in  1  one-cycle start pulse from register block
cfg_base_addr  in  ADDR_WIDTH  destination byte address
cfg_len_bytes  in  LEN_WIDTH  transfer length in bytes
busy  out  1  high from accepted start until done
done  out  1  one-cycle completion pulse
err_unaligned  out  1  sticky: base or length not BPB-aligned
err_slverr  out  1  sticky: any non-OKAY BRESP seen
m_axi_awaddr  out  ADDR_WIDTH  burst start address
m_axi_awlen  out  8  beats-1
m_axi_awsize  out  3  constant log2(BPB) (3'b010 at 32-bit)
m_axi_awburst  out  2  constant 2'b01 INCR
m_axi_awvalid  out  1  AW request
m_axi_awready  in  1  AW accept
m_axi_bvalid  in  1  write response valid
m_axi_bresp  in  2  write response
m_axi_bready  out  1  response accept
wcmd_valid  out  1  beat-count command to W engine
wcmd_beats  out  9  beats in this burst (1..MAX_BURST)
wcmd_ready  in  1  W engine accepts command

Behaviour:
- Reset values: busy, done, err_*, awvalid, wcmd_valid, bready = 0; awaddr, awlen, wcmd_beats = 0. awsize and awburst are constants. Reset mid-transfer aborts the transfer, clears all counters and returns to IDLE.
- FSM states: IDLE, CHECK, ISSUE, DRAIN, DONE.
- IDLE: cfg_start latches base/len. err flags clear, busy=1 next cycle, go to CHECK. cfg_start is ignored in every other state.
- CHECK (1 cycle):
  - base or len not a multiple of BPB: set err_unaligned, go to DONE, issue no AW.
  - len==0: go to DONE, no error.
  - otherwise compute remaining beats = len/BPB and go to ISSUE.
- Burst sizing: beats = min(remaining, MAX_BURST, (4096 - addr[11:0])/BPB). Compute in 13-bit arithmetic so a page-aligned address yields 4096/BPB.
- ISSUE:
  - Stall with awvalid=0 while outstanding==MAX_OUTSTANDING.
  - Otherwise assert awvalid and wcmd_valid together with awlen=beats-1 and wcmd_beats=beats.
  - Each valid drops independently on its own handshake. AW and wcmd payloads stay stable while their valid is high.
  - When both have handshaken: addr += beats*BPB, remaining -= beats.
  - remaining==0 moves to DRAIN; otherwise the next burst may present on the following cycle.
- Outstanding counter: +1 on AW handshake, -1 on B handshake. Simultaneous increment and decrement leaves it unchanged.
- bready=1 whenever busy. A B handshake while not busy is ignored.
- Any B handshake with bresp!=2'b00 sets err_slverr. The transfer continues to completion (no abort).
- DRAIN: wait for outstanding==0, then go to DONE.
- DONE: done=1 for one cycle, busy=0, go to IDLE. Error flags hold until the next accepted start.

Test Plan:
- Aligned single burst: base 0x1000_0000, len 64 → one AW, awaddr=0x1000_0000, awlen=15, awsize=010, awburst=01, wcmd_beats=16. done pulses after B=OKAY; errors=0.
- Multi-burst: base 0x2000_0000, len 200 → bursts 16/16/16/2 beats at 0x2000_0000, 0x2000_0040, 0x2000_0080, 0x2000_00C0. done only after the 4th B.
- 4KB crossing: base 0x1000_0FF0, len 64 → AW0 at 0x1000_0FF0 with awlen=3, then AW1 at 0x1000_1000 with awlen=11.
- Unaligned: base 0x1000_0007, len 64 → err_unaligned=1 and a done pulse; awvalid and wcmd_valid never assert. A following aligned start clears err_unaligned.
- Backpressure/outstanding:
  - MAX_OUTSTANDING=2, len 256, B withheld → exactly 2 AWs issued, 3rd stalls until the first B.
  - awready held low 5 cycles → awaddr/awlen stable and awvalid held.
- SLVERR and reset: return bresp=2'b10 on burst 2 of 4 → err_slverr=1, all 4 bursts still issued, done pulses. rst_n asserted mid-ISSUE → all outputs return to reset values; a new start then behaves normally.
